// File: rtl/wb_stage.sv
// Writeback stage: merges the ALU path with a small load-result FIFO into one
// registered register-file write per cycle, with load formatting and a retire counter.
module wb_stage #(
    parameter int unsigned LSU_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_alu_valid,
    input  logic [4:0]  i_alu_rd_5,
    input  logic [63:0] i_alu_data_64,
    input  logic        i_lsu_valid,
    output logic        o_lsu_ready,
    input  logic [4:0]  i_lsu_rd_5,
    input  logic [63:0] i_lsu_data_64,
    input  logic [2:0]  i_lsu_funct3_3,
    input  logic [2:0]  i_lsu_off_3,
    output logic        o_wen,
    output logic [4:0]  o_waddr_5,
    output logic [63:0] o_wdata_64,
    output logic [63:0] o_retire_cnt_64
);

    localparam int unsigned AW = $clog2(LSU_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(LSU_DEPTH);

    logic [63:0] fifo_data [LSU_DEPTH];
    logic [4:0]  fifo_rd   [LSU_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [63:0]   retire_q;

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] word_s;
    logic [63:0] ld_fmt;
    logic        push;
    logic        pop;
    logic        slot_take;
    logic [4:0]  slot_rd;
    logic [63:0] slot_data;

    assign o_lsu_ready     = (count < DEPTH_C);
    assign push            = i_lsu_valid && o_lsu_ready;
    // Pop is gated by the registered count, so a same-cycle push never falls through.
    assign pop             = !i_alu_valid && (count != '0);
    assign slot_take       = i_alu_valid || pop;
    assign o_retire_cnt_64 = retire_q;

    always_comb begin
        byte_s = i_lsu_data_64[{i_lsu_off_3, 3'b000} +: 8];
        half_s = i_lsu_data_64[{i_lsu_off_3[2:1], 4'b0000} +: 16];
        word_s = i_lsu_data_64[{i_lsu_off_3[2], 5'b00000} +: 32];
        ld_fmt = i_lsu_data_64;
        case (i_lsu_funct3_3)
            3'b000:  ld_fmt = {{56{byte_s[7]}}, byte_s};
            3'b100:  ld_fmt = {56'd0, byte_s};
            3'b001:  ld_fmt = {{48{half_s[15]}}, half_s};
            3'b101:  ld_fmt = {48'd0, half_s};
            3'b010:  ld_fmt = {{32{word_s[31]}}, word_s};
            3'b110:  ld_fmt = {32'd0, word_s};
            default: ld_fmt = i_lsu_data_64;
        endcase
    end

    always_comb begin
        slot_rd   = fifo_rd[rd_ptr];
        slot_data = fifo_data[rd_ptr];
        if (i_alu_valid) begin
            slot_rd   = i_alu_rd_5;
            slot_data = i_alu_data_64;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= ld_fmt;
            fifo_rd[wr_ptr]   <= i_lsu_rd_5;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_wen      <= 1'b0;
            o_waddr_5  <= '0;
            o_wdata_64 <= '0;
            retire_q   <= '0;
        end else if (slot_take) begin
            o_wen      <= (slot_rd != 5'd0);
            o_waddr_5  <= slot_rd;
            o_wdata_64 <= slot_data;
            retire_q   <= retire_q + 64'd1;
        end else begin
            o_wen <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: table of single-result vectors plus hand-written
// sequences for arbitration/backpressure, mid-cycle reset and counter wrap.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        lsu_v;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [63:0] lsu_data;
    logic [2:0]  lsu_f3;
    logic [2:0]  lsu_off;
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [63:0] cnt;

    int unsigned total;
    int unsigned bad;

    wb_stage #(.LSU_DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_alu_valid     (alu_v),
        .i_alu_rd_5      (alu_rd),
        .i_alu_data_64   (alu_data),
        .i_lsu_valid     (lsu_v),
        .o_lsu_ready     (lsu_ready),
        .i_lsu_rd_5      (lsu_rd),
        .i_lsu_data_64   (lsu_data),
        .i_lsu_funct3_3  (lsu_f3),
        .i_lsu_off_3     (lsu_off),
        .o_wen           (wen),
        .o_waddr_5       (waddr),
        .o_wdata_64      (wdata),
        .o_retire_cnt_64 (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        is_lsu;
        logic [4:0]  rd;
        logic [63:0] data;
        logic [2:0]  f3;
        logic [2:0]  off;
        logic        exp_wen;
        logic [63:0] exp_wdata;
    } vec_t;

    localparam logic [63:0] LDV = 64'h8877665544332211;

    vec_t        vecs [13];
    logic [63:0] exp_cnt;
    logic [4:0]  last_addr;
    logic [63:0] last_data;
    logic        exp_ready [6];
    int unsigned sent;
    logic        acc;

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0;
        alu_v = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_v = 1'b0; lsu_rd = '0; lsu_data = '0; lsu_f3 = '0; lsu_off = '0;

        vecs[0]  = '{1'b0, 5'd5,  64'h1234, 3'd0, 3'd0, 1'b1, 64'h1234};
        vecs[1]  = '{1'b0, 5'd0,  64'hDEAD, 3'd0, 3'd0, 1'b0, 64'hDEAD};
        vecs[2]  = '{1'b1, 5'd1,  LDV, 3'b000, 3'd7, 1'b1, 64'hFFFFFFFFFFFFFF88};
        vecs[3]  = '{1'b1, 5'd2,  LDV, 3'b100, 3'd7, 1'b1, 64'h88};
        vecs[4]  = '{1'b1, 5'd3,  LDV, 3'b001, 3'd2, 1'b1, 64'h4433};
        vecs[5]  = '{1'b1, 5'd4,  LDV, 3'b110, 3'd4, 1'b1, 64'h88776655};
        vecs[6]  = '{1'b1, 5'd31, LDV, 3'b011, 3'd3, 1'b1, LDV};
        vecs[7]  = '{1'b1, 5'd6,  LDV, 3'b101, 3'd6, 1'b1, 64'h8877};
        vecs[8]  = '{1'b1, 5'd7,  LDV, 3'b010, 3'd4, 1'b1, 64'hFFFFFFFF88776655};
        vecs[9]  = '{1'b1, 5'd8,  LDV, 3'b010, 3'd0, 1'b1, 64'h44332211};
        vecs[10] = '{1'b1, 5'd9,  LDV, 3'b111, 3'd5, 1'b1, LDV};
        vecs[11] = '{1'b1, 5'd10, LDV, 3'b001, 3'd0, 1'b1, 64'h2211};
        vecs[12] = '{1'b1, 5'd0,  64'h0123456789ABCDEF, 3'b011, 3'd0, 1'b0, 64'h0123456789ABCDEF};

        #12 rst = 1'b1;
        tick();
        chk("rst_wen",   {63'd0, wen}, 64'd0);
        chk("rst_waddr", {59'd0, waddr}, 64'd0);
        chk("rst_wdata", wdata, 64'd0);
        chk("rst_cnt",   cnt, 64'd0);
        chk("rst_ready", {63'd0, lsu_ready}, 64'd1);
        exp_cnt = 64'd0;

        // Table: one result per vector, checked at its latency, then one idle cycle.
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_lsu) begin
                lsu_v = 1'b1; lsu_rd = vecs[i].rd; lsu_data = vecs[i].data;
                lsu_f3 = vecs[i].f3; lsu_off = vecs[i].off;
                chk($sformatf("v%0d_ready", i), {63'd0, lsu_ready}, 64'd1);
            end else begin
                alu_v = 1'b1; alu_rd = vecs[i].rd; alu_data = vecs[i].data;
            end
            tick();
            alu_v = 1'b0;
            lsu_v = 1'b0;
            if (vecs[i].is_lsu) begin
                chk($sformatf("v%0d_nofall", i), {63'd0, wen}, 64'd0);
                tick();
            end
            exp_cnt++;
            chk($sformatf("v%0d_wen", i),   {63'd0, wen}, {63'd0, vecs[i].exp_wen});
            chk($sformatf("v%0d_waddr", i), {59'd0, waddr}, {59'd0, vecs[i].rd});
            chk($sformatf("v%0d_wdata", i), wdata, vecs[i].exp_wdata);
            chk($sformatf("v%0d_cnt", i),   cnt, exp_cnt);
            tick();
            chk($sformatf("v%0d_idle_wen", i),   {63'd0, wen}, 64'd0);
            chk($sformatf("v%0d_idle_waddr", i), {59'd0, waddr}, {59'd0, vecs[i].rd});
            chk($sformatf("v%0d_idle_wdata", i), wdata, vecs[i].exp_wdata);
            chk($sformatf("v%0d_idle_cnt", i),   cnt, exp_cnt);
        end

        // Arbitration: 4 ALU cycles while 3 loads are offered to a depth-2 FIFO.
        exp_ready[0] = 1'b1; exp_ready[1] = 1'b1; exp_ready[2] = 1'b0;
        exp_ready[3] = 1'b0; exp_ready[4] = 1'b0; exp_ready[5] = 1'b1;
        sent = 0;
        for (int k = 0; k < 9; k++) begin
            alu_v    = (k < 4);
            alu_rd   = 5'(10 + k);
            alu_data = 64'hA000 + 64'(k);
            lsu_v    = (sent < 3);
            lsu_rd   = 5'(20 + sent);
            lsu_data = 64'hB000 + 64'(sent);
            lsu_f3   = 3'b011;
            lsu_off  = 3'd0;
            acc = (k < 6) ? exp_ready[k] : 1'b1;
            if (k < 6) chk($sformatf("arb%0d_ready", k), {63'd0, lsu_ready}, {63'd0, exp_ready[k]});
            if (lsu_v && acc) sent++;
            tick();
            alu_v = 1'b0;
            lsu_v = 1'b0;
            if (k < 4) begin
                exp_cnt++;
                chk($sformatf("arb%0d_wen", k),   {63'd0, wen}, 64'd1);
                chk($sformatf("arb%0d_waddr", k), {59'd0, waddr}, 64'(10 + k));
                chk($sformatf("arb%0d_wdata", k), wdata, 64'hA000 + 64'(k));
            end else if (k < 7) begin
                exp_cnt++;
                chk($sformatf("arb%0d_wen", k),   {63'd0, wen}, 64'd1);
                chk($sformatf("arb%0d_waddr", k), {59'd0, waddr}, 64'(20 + k - 4));
                chk($sformatf("arb%0d_wdata", k), wdata, 64'hB000 + 64'(k - 4));
            end else begin
                chk($sformatf("arb%0d_wen", k), {63'd0, wen}, 64'd0);
            end
            chk($sformatf("arb%0d_cnt", k), cnt, exp_cnt);
        end
        chk("arb_total", cnt, 64'd13 + 64'd7);

        // Reset mid-cycle with a full FIFO and ALU traffic active.
        for (int k = 0; k < 3; k++) begin
            alu_v = 1'b1; alu_rd = 5'd15; alu_data = 64'h55;
            lsu_v = 1'b1; lsu_rd = 5'(25 + k); lsu_data = 64'hC000 + 64'(k); lsu_f3 = 3'b011;
            tick();
        end
        chk("mid_pre_wen",   {63'd0, wen}, 64'd1);
        chk("mid_pre_ready", {63'd0, lsu_ready}, 64'd0);
        #3 rst = 1'b0;
        #1;
        chk("mid_wen",   {63'd0, wen}, 64'd0);
        chk("mid_waddr", {59'd0, waddr}, 64'd0);
        chk("mid_wdata", wdata, 64'd0);
        chk("mid_cnt",   cnt, 64'd0);
        chk("mid_ready", {63'd0, lsu_ready}, 64'd1);
        alu_v = 1'b0;
        lsu_v = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("post%0d_wen", k), {63'd0, wen}, 64'd0);
        end
        chk("post_cnt", cnt, 64'd0);

        // Counter wrap: preload all-ones, retire one ALU result.
        force dut.retire_q = '1;
        #1;
        release dut.retire_q;
        chk("wrap_pre", cnt, 64'hFFFFFFFFFFFFFFFF);
        alu_v = 1'b1; alu_rd = 5'd3; alu_data = 64'd7;
        @(posedge clk);
        #1;
        alu_v = 1'b0;
        chk("wrap_cnt",   cnt, 64'd0);
        chk("wrap_wen",   {63'd0, wen}, 64'd1);
        chk("wrap_wdata", wdata, 64'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
